// File: rtl/proc_trace_pkg.sv
// Shared types and defaults for the processor trace buffer.
// The record layout gains a cycle stamp when PROC_TRACE_TIMESTAMP_EN is defined.
package proc_trace_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int DROP_W_DEF = 16;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
`ifdef PROC_TRACE_TIMESTAMP_EN
        logic [XLEN-1:0] cycle;
`endif
    } trace_rec_t;

endpackage

// File: rtl/proc_trace_fifo.sv
// Trace record FIFO: storage array, head/tail pointers with wrap bit, full/empty and occupancy.
module proc_trace_fifo
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  trace_rec_t    rec_i,
    input  logic          pop_i,
    output trace_rec_t    rec_o,
    output logic          val_o,
    output logic          full_o,
    output logic [PW-1:0] count_o
);

    localparam int            AW       = PW - 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] count_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    trace_rec_t    mem_q [DEPTH];

    // The pointer MSB is a lap bit, so tail - head is the occupancy even when full.
    assign count_s = tail_q - head_q;
    assign empty_s = (count_s == {PW{1'b0}});
    assign full_o  = (count_s == FULL_CNT);
    assign pop_s   = pop_i && !empty_s;
    assign push_s  = push_i && (!full_o || pop_s);

    // Next-state pointers.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= {PW{1'b0}};
            tail_q <= {PW{1'b0}};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage write; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_s && !rst_i) begin
            mem_q[tail_q[AW-1:0]] <= rec_i;
        end
    end

    assign rec_o   = mem_q[head_q[AW-1:0]];
    assign val_o   = !empty_s;
    assign count_o = count_s;

endmodule

// File: rtl/proc_trace_buffer.sv
// Processor trace capture buffer with drop accounting and valid/ready dequeue.
// Define PROC_TRACE_TIMESTAMP_EN to stamp each record with a free-running cycle count.
module proc_trace_buffer
    import proc_trace_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_val,
    input  logic [31:0]              trace_addr,
    input  logic [31:0]              trace_data,
    output logic                     deq_val,
    input  logic                     deq_rdy,
    output logic [31:0]              deq_addr,
    output logic [31:0]              deq_data,
    output logic [31:0]              deq_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drops,
    input  logic                     clear
);

    localparam logic [DROP_W-1:0] DROPS_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROPS_ONE = DROP_W'(1);

    trace_rec_t        wr_rec_s;
    trace_rec_t        rd_rec_s;
    logic              full_s;
    logic              drop_s;
    logic              overflow_q, overflow_d, overflow_base_s;
    logic [DROP_W-1:0] drops_q, drops_d, drops_base_s;

`ifdef PROC_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_q, cycle_d;

    // Free-running stamp counter, wraps naturally at 2^32.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
    end

    // Stamp counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= 32'd0;
        end else begin
            cycle_q <= cycle_d;
        end
    end
`endif

    // Record assembly for the write port.
    always_comb begin
        wr_rec_s.addr  = trace_addr;
        wr_rec_s.data  = trace_data;
`ifdef PROC_TRACE_TIMESTAMP_EN
        wr_rec_s.cycle = cycle_q;
`endif
    end

    proc_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (trace_val),
        .rec_i   (wr_rec_s),
        .pop_i   (deq_rdy),
        .rec_o   (rd_rec_s),
        .val_o   (deq_val),
        .full_o  (full_s),
        .count_o (count)
    );

    // A full FIFO frees a slot only when the reader dequeues in the same cycle.
    assign drop_s = trace_val && full_s && !(deq_val && deq_rdy);

    // Clear is applied first so a coincident drop still registers.
    always_comb begin
        overflow_d = overflow_q;
        drops_d    = drops_q;
        if (clear) begin
            overflow_base_s = 1'b0;
            drops_base_s    = {DROP_W{1'b0}};
        end else begin
            overflow_base_s = overflow_q;
            drops_base_s    = drops_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
            drops_d    = (drops_base_s == DROPS_MAX) ? drops_base_s : drops_base_s + DROPS_ONE;
        end else begin
            overflow_d = overflow_base_s;
            drops_d    = drops_base_s;
        end
    end

    // Drop accounting registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drops_q    <= {DROP_W{1'b0}};
        end else begin
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    assign deq_addr = rd_rec_s.addr;
    assign deq_data = rd_rec_s.data;
`ifdef PROC_TRACE_TIMESTAMP_EN
    assign deq_cycle = rd_rec_s.cycle;
`else
    assign deq_cycle = 32'd0;
`endif
    assign overflow = overflow_q;
    assign drops    = drops_q;

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Self-checking bench for proc_trace_buffer: vector table for status, scoreboard queue for record order.
module tb_proc_trace_buffer;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              trace_val;
    logic [31:0]       trace_addr;
    logic [31:0]       trace_data;
    logic              deq_val;
    logic              deq_rdy;
    logic [31:0]       deq_addr;
    logic [31:0]       deq_data;
    logic [31:0]       deq_cycle;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [DROP_W-1:0] drops;
    logic              clear;

    always #5 clk = ~clk;

    proc_trace_buffer #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .deq_val    (deq_val),
        .deq_rdy    (deq_rdy),
        .deq_addr   (deq_addr),
        .deq_data   (deq_data),
        .deq_cycle  (deq_cycle),
        .count      (count),
        .overflow   (overflow),
        .drops      (drops),
        .clear      (clear)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cycle;
    } sb_t;

    typedef struct {
        logic        tv;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        int          e_cnt;
        logic        e_ovf;
        int          e_drops;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_m    = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic add(input logic tv, input logic [31:0] a, input logic [31:0] d, input logic rdy,
                       input int e_cnt, input logic e_ovf, input int e_drops);
        vec_t v;
        v.tv = tv; v.addr = a; v.data = d; v.rdy = rdy;
        v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_drops = e_drops;
        vecs.push_back(v);
    endtask

    // One clock: drive, advance the reference queue, then compare status and head record.
    task automatic step(input logic tv, input logic [31:0] a, input logic [31:0] d, input logic rdy,
                        input logic clr, input logic r, input int e_cnt, input logic e_ovf,
                        input int e_drops, input string nm);
        sb_t rec;
        trace_val  = tv;
        trace_addr = a;
        trace_data = d;
        deq_rdy    = rdy;
        clear      = clr;
        rst        = r;
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            cyc_m = 0;
        end else begin
            if (rdy && sb_q.size() > 0) rec = sb_q.pop_front();
            if (tv && sb_q.size() < DEPTH) begin
                rec.addr = a;
                rec.data = d;
`ifdef PROC_TRACE_TIMESTAMP_EN
                rec.cycle = 32'(cyc_m);
`else
                rec.cycle = 32'd0;
`endif
                sb_q.push_back(rec);
            end
            cyc_m++;
        end
        check32($sformatf("%s.count", nm), 32'(count), 32'(e_cnt));
        check32($sformatf("%s.deq_val", nm), 32'(deq_val), 32'(e_cnt != 0));
        check32($sformatf("%s.overflow", nm), 32'(overflow), 32'(e_ovf));
        check32($sformatf("%s.drops", nm), 32'(drops), 32'(e_drops));
        if (sb_q.size() > 0) begin
            check32($sformatf("%s.deq_addr", nm), deq_addr, sb_q[0].addr);
            check32($sformatf("%s.deq_data", nm), deq_data, sb_q[0].data);
            check32($sformatf("%s.deq_cycle", nm), deq_cycle, sb_q[0].cycle);
        end
    endtask

    initial begin
        logic [31:0] exp_c3;
        logic [31:0] exp_c7;
        rst = 1'b1; trace_val = 1'b0; trace_addr = 32'd0; trace_data = 32'd0;
        deq_rdy = 1'b0; clear = 1'b0;

        // single record round trip
        add(1'b1, 32'h200, 32'h5, 1'b0, 1, 1'b0, 0);
        add(1'b0, 32'h0,   32'h0, 1'b0, 1, 1'b0, 0);
        add(1'b0, 32'h0,   32'h0, 1'b1, 0, 1'b0, 0);
        // fill past capacity
        for (int i = 0; i < 10; i++)
            add(1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0,
                (i < 8) ? i + 1 : 8, (i >= 8), (i >= 8) ? i - 7 : 0);
        // full with simultaneous enqueue and dequeue, then drain
        add(1'b1, 32'h300, 32'h3, 1'b1, 8, 1'b1, 2);
        for (int i = 0; i < 8; i++)
            add(1'b0, 32'h0, 32'h0, 1'b1, 7 - i, 1'b1, 2);
        // streaming: empty dequeue is a no-op, then steady one-in one-out
        add(1'b1, 32'h400, 32'h40, 1'b1, 1, 1'b1, 2);
        for (int i = 1; i < 5; i++)
            add(1'b1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i), 1'b1, 1, 1'b1, 2);
        add(1'b0, 32'h0, 32'h0, 1'b1, 0, 1'b1, 2);

        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, "reset0");
        step(1'b1, 32'hDEAD, 32'h1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, "reset1");

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].tv, vecs[i].addr, vecs[i].data, vecs[i].rdy, 1'b0, 1'b0,
                 vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_drops, $sformatf("vec%0d", i));

        // clear coinciding with a drop, then clear alone
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'h500 + 32'(4 * i), 32'h50 + 32'(i), 1'b0, 1'b0, 1'b0, i + 1, 1'b1, 2, "refill");
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h600 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 3 + i, "drop_to5");
        step(1'b1, 32'h700, 32'h0, 1'b0, 1'b1, 1'b0, 8, 1'b1, 1, "clr_drop");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 8, 1'b0, 0, "clr_only");

        // drop counter saturates at all-ones
        for (int i = 0; i < 17; i++)
            step(1'b1, 32'h800 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0, 8, 1'b1, (i < 15) ? i + 1 : 15, "sat");

        // reset with entries queued
        for (int i = 0; i < 5; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 7 - i, 1'b1, 15, "drain_to3");
        step(1'b1, 32'h900, 32'h9, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, "rst_busy");

        // records in cycles 3 and 7 after reset
        for (int k = 0; k < 8; k++)
            step((k == 3 || k == 7), 32'hA00 + 32'(k), 32'(k), 1'b0, 1'b0, 1'b0,
                 (k < 3) ? 0 : ((k < 7) ? 1 : 2), 1'b0, 0, "ts");
`ifdef PROC_TRACE_TIMESTAMP_EN
        exp_c3 = 32'd3;
        exp_c7 = 32'd7;
`else
        exp_c3 = 32'd0;
        exp_c7 = 32'd0;
`endif
        check32("ts_first_cycle", deq_cycle, exp_c3);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 0, "ts_pop1");
        check32("ts_second_cycle", deq_cycle, exp_c7);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, "ts_pop2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
